// File: rtl/song_transport_ctrl.sv
// Transport FSM and per-song ZBT address sequencer for the audio memory path.
// Addresses advance one word per three samples; a per-song length table bounds playback.
module song_transport_ctrl #(
    parameter int REGION_W = 16,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              btn_play,
    input  logic              btn_record,
    input  logic              btn_pause,
    input  logic              btn_stop,
    input  logic [3:0]        song_sel,
    output logic              start_song,
    output logic [3:0]        song_choice,
    output logic              record_mode,
    output logic              pause_song,
    output logic              song_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        state_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_PLAY   = 3'd2,
        S_RECORD = 3'd3,
        S_PAUSED = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [REGION_W-1:0] OFF_MAX = '1;

    state_t              r_state;
    logic                r_start_song;
    logic [3:0]          r_song_choice;
    logic                r_record_mode;
    logic                r_pause_song;
    logic                r_song_done;
    logic [1:0]          r_phase;
    logic [REGION_W-1:0] r_word_offset;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [REGION_W-1:0] r_len [16];

    logic                w_stop, w_rec, w_play, w_pause;
    logic                w_go_start;
    logic                w_word_step;
    logic [REGION_W-1:0] w_off_inc;
    logic [REGION_W-1:0] w_len_cur;

    // Only the highest-priority pulse acts: stop > record > play > pause.
    assign w_stop      = btn_stop;
    assign w_rec       = btn_record & ~btn_stop;
    assign w_play      = btn_play & ~btn_stop & ~btn_record;
    assign w_pause     = btn_pause & ~btn_stop & ~btn_record & ~btn_play;
    assign w_go_start  = ((r_state == S_IDLE) || (r_state == S_DONE)) && (w_rec || w_play);
    assign w_word_step = (r_phase == 2'd2);
    assign w_off_inc   = r_word_offset + 1'b1;
    assign w_len_cur   = r_len[r_song_choice];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_start_song  <= 1'b0;
            r_song_choice <= '0;
            r_record_mode <= 1'b0;
            r_pause_song  <= 1'b0;
            r_song_done   <= 1'b0;
            r_phase       <= '0;
            r_word_offset <= '0;
            r_mem_addr    <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                r_len[i] <= '0;
            end
        end else begin
            r_start_song <= 1'b0;
            if (w_go_start) begin
                // Counters are cleared on entry so START already presents offset 0.
                r_state       <= S_START;
                r_start_song  <= 1'b1;
                r_record_mode <= w_rec;
                r_song_choice <= song_sel;
                r_song_done   <= 1'b0;
                r_phase       <= '0;
                r_word_offset <= '0;
                r_mem_addr    <= {song_sel[2:0], {REGION_W{1'b0}}};
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_START: begin
                        if (r_record_mode) begin
                            r_state <= S_RECORD;
                        end else if (w_len_cur != '0) begin
                            r_state <= S_PLAY;
                        end else begin
                            r_state     <= S_DONE;
                            r_song_done <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (w_stop) begin
                            r_state <= S_IDLE;
                        end else if (r_word_offset == w_len_cur) begin
                            r_state     <= S_DONE;
                            r_song_done <= 1'b1;
                        end else if (w_pause) begin
                            r_state      <= S_PAUSED;
                            r_pause_song <= 1'b1;
                        end else if (ready) begin
                            if (w_word_step) begin
                                r_phase       <= '0;
                                r_word_offset <= w_off_inc;
                                r_mem_addr    <= {r_song_choice[2:0], w_off_inc};
                            end else begin
                                r_phase <= r_phase + 2'd1;
                            end
                        end
                    end
                    S_RECORD: begin
                        if (w_stop) begin
                            r_len[r_song_choice] <= r_word_offset;
                            r_state              <= S_IDLE;
                        end else if (w_pause) begin
                            r_state      <= S_PAUSED;
                            r_pause_song <= 1'b1;
                        end else if (ready) begin
                            if (w_word_step && (r_word_offset == OFF_MAX)) begin
                                // Region full: the offset saturates instead of wrapping.
                                r_len[r_song_choice] <= OFF_MAX;
                                r_phase              <= '0;
                                r_state              <= S_DONE;
                                r_song_done          <= 1'b1;
                            end else if (w_word_step) begin
                                r_phase       <= '0;
                                r_word_offset <= w_off_inc;
                                r_mem_addr    <= {r_song_choice[2:0], w_off_inc};
                            end else begin
                                r_phase <= r_phase + 2'd1;
                            end
                        end
                    end
                    S_PAUSED: begin
                        // record_mode doubles as the saved mode to resume into.
                        if (w_stop) begin
                            if (r_record_mode) begin
                                r_len[r_song_choice] <= r_word_offset;
                            end
                            r_state      <= S_IDLE;
                            r_pause_song <= 1'b0;
                        end else if (w_play || w_pause) begin
                            r_state      <= r_record_mode ? S_RECORD : S_PLAY;
                            r_pause_song <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        if (w_stop) begin
                            r_state     <= S_IDLE;
                            r_song_done <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign start_song  = r_start_song;
    assign song_choice = r_song_choice;
    assign record_mode = r_record_mode;
    assign pause_song  = r_pause_song;
    assign song_done   = r_song_done;
    assign mem_addr    = r_mem_addr;
    assign state_out   = r_state;

endmodule

// File: tb/tb_song_transport_ctrl.sv
// Bench for song_transport_ctrl: a full-size and a 2-bit-region instance share stimulus
// and are checked every cycle against a sample-count model, plus literal spot checks.
module tb_song_transport_ctrl;

    localparam int M_IDLE = 0, M_START = 1, M_PLAY = 2, M_REC = 3, M_PAUSED = 4, M_DONE = 5;

    logic clk = 1'b0;
    logic reset, ready, btn_play, btn_record, btn_pause, btn_stop;
    logic [3:0] song_sel;

    logic        b_start, b_rm, b_pz, b_dn;
    logic [3:0]  b_ch;
    logic [18:0] b_addr;
    logic [2:0]  b_st;
    logic        s_start, s_rm, s_pz, s_dn;
    logic [3:0]  s_ch;
    logic [4:0]  s_addr;
    logic [2:0]  s_st;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a take is tracked as a count of accepted samples; word offset = count / 3.
    int m_st[2], m_ch[2], m_rm[2], m_pz[2], m_dn[2], m_ss[2], m_cnt[2];
    int m_len[2][16];
    int m_rw[2]  = '{16, 2};
    int m_max[2] = '{65535, 3};

    always #5 clk = ~clk;

    song_transport_ctrl #(.REGION_W(16), .ADDR_W(19)) dut (
        .clk(clk), .reset(reset), .ready(ready), .btn_play(btn_play), .btn_record(btn_record),
        .btn_pause(btn_pause), .btn_stop(btn_stop), .song_sel(song_sel),
        .start_song(b_start), .song_choice(b_ch), .record_mode(b_rm), .pause_song(b_pz),
        .song_done(b_dn), .mem_addr(b_addr), .state_out(b_st)
    );

    song_transport_ctrl #(.REGION_W(2), .ADDR_W(5)) dut_s (
        .clk(clk), .reset(reset), .ready(ready), .btn_play(btn_play), .btn_record(btn_record),
        .btn_pause(btn_pause), .btn_stop(btn_stop), .song_sel(song_sel),
        .start_song(s_start), .song_choice(s_ch), .record_mode(s_rm), .pause_song(s_pz),
        .song_done(s_dn), .mem_addr(s_addr), .state_out(s_st)
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got 0x%0h, expected 0x%0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        int  off;
        bit  sp, rc, pl, pa;
        sp  = btn_stop;
        rc  = btn_record && !sp;
        pl  = btn_play && !sp && !rc;
        pa  = btn_pause && !sp && !rc && !pl;
        off = m_cnt[k] / 3;
        m_ss[k] = 0;
        if (reset) begin
            m_st[k] = M_IDLE; m_ch[k] = 0; m_rm[k] = 0; m_pz[k] = 0; m_dn[k] = 0; m_cnt[k] = 0;
            for (int i = 0; i < 16; i++) m_len[k][i] = 0;
        end else if ((m_st[k] == M_IDLE || m_st[k] == M_DONE) && (rc || pl)) begin
            m_st[k] = M_START; m_ss[k] = 1; m_rm[k] = rc ? 1 : 0;
            m_ch[k] = int'(song_sel); m_cnt[k] = 0; m_dn[k] = 0;
        end else begin
            case (m_st[k])
                M_START: begin
                    if (m_rm[k] != 0) m_st[k] = M_REC;
                    else if (m_len[k][m_ch[k]] != 0) m_st[k] = M_PLAY;
                    else begin m_st[k] = M_DONE; m_dn[k] = 1; end
                end
                M_PLAY: begin
                    if (sp) m_st[k] = M_IDLE;
                    else if (off == m_len[k][m_ch[k]]) begin m_st[k] = M_DONE; m_dn[k] = 1; end
                    else if (pa) begin m_st[k] = M_PAUSED; m_pz[k] = 1; end
                    else if (ready) m_cnt[k]++;
                end
                M_REC: begin
                    if (sp) begin m_len[k][m_ch[k]] = off; m_st[k] = M_IDLE; end
                    else if (pa) begin m_st[k] = M_PAUSED; m_pz[k] = 1; end
                    else if (ready) begin
                        if (m_cnt[k] % 3 == 2 && off == m_max[k]) begin
                            m_len[k][m_ch[k]] = m_max[k]; m_st[k] = M_DONE; m_dn[k] = 1;
                        end else m_cnt[k]++;
                    end
                end
                M_PAUSED: begin
                    if (sp) begin
                        if (m_rm[k] != 0) m_len[k][m_ch[k]] = off;
                        m_st[k] = M_IDLE; m_pz[k] = 0;
                    end else if (pl || pa) begin
                        m_st[k] = (m_rm[k] != 0) ? M_REC : M_PLAY; m_pz[k] = 0;
                    end
                end
                M_DONE: if (sp) begin m_st[k] = M_IDLE; m_dn[k] = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic cmp(input int k, input logic [2:0] st, input logic ss, input logic [3:0] ch,
                       input logic rm, input logic pz, input logic dn, input logic [31:0] addr);
        int exp_addr;
        exp_addr = ((m_ch[k] % 8) << m_rw[k]) | (m_cnt[k] / 3);
        chk("state_out",   k, 32'(st), 32'(m_st[k]));
        chk("start_song",  k, 32'(ss), 32'(m_ss[k]));
        chk("song_choice", k, 32'(ch), 32'(m_ch[k]));
        chk("record_mode", k, 32'(rm), 32'(m_rm[k]));
        chk("pause_song",  k, 32'(pz), 32'(m_pz[k]));
        chk("song_done",   k, 32'(dn), 32'(m_dn[k]));
        chk("mem_addr",    k, addr, 32'(exp_addr));
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        cmp(0, b_st, b_start, b_ch, b_rm, b_pz, b_dn, 32'(b_addr));
        cmp(1, s_st, s_start, s_ch, s_rm, s_pz, s_dn, 32'(s_addr));
    end

    task automatic step(input logic rdy, input logic pl, input logic rc, input logic pa, input logic sp);
        ready = rdy; btn_play = pl; btn_record = rc; btn_pause = pa; btn_stop = sp;
        @(negedge clk);
        ready = 1'b0; btn_play = 1'b0; btn_record = 1'b0; btn_pause = 1'b0; btn_stop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic spaced_readies(input int n);
        repeat (n) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(1);
        end
    endtask

    initial begin
        reset = 1'b1; ready = 1'b0; btn_play = 1'b0; btn_record = 1'b0;
        btn_pause = 1'b0; btn_stop = 1'b0; song_sel = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_state", 0, 32'(b_st), 32'd0);
        chk("rst_addr",  0, 32'(b_addr), 32'd0);

        // Record song 10 for nine samples, then stop.
        song_sel = 4'b1010;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lit_start_pulse", 0, 32'(b_start), 32'd1);
        chk("lit_rec_mode",    0, 32'(b_rm), 32'd1);
        idle(1);
        chk("lit_start_gone",  0, 32'(b_start), 32'd0);
        spaced_readies(9);
        chk("lit_rec_addr",    0, 32'(b_addr), 32'h20003);
        chk("lit_rec_addr",    1, 32'(s_addr), 32'h0B);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_idle", 0, 32'(b_st), 32'd0);

        // Play song 10 with continuous samples until done.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (14) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_play_done", 0, 32'(b_dn), 32'd1);
        chk("lit_play_addr", 0, 32'(b_addr), 32'h20003);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Play an unrecorded song.
        song_sel = 4'd5;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_empty_start", 0, 32'(b_st), 32'd1);
        idle(1);
        chk("lit_empty_done", 0, 32'(b_st), 32'd5);
        chk("lit_empty_addr", 0, 32'(b_addr), 32'h50000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Record with a pause in the middle.
        song_sel = 4'd3;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        spaced_readies(4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_paused", 0, 32'(b_pz), 32'd1);
        spaced_readies(5);
        chk("lit_pause_addr", 0, 32'(b_addr), 32'h30001);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_resume_addr1", 0, 32'(b_addr), 32'h30001);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_resume_addr2", 0, 32'(b_addr), 32'h30002);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Play song 3, pause/resume, then stop and play together.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        spaced_readies(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_play_resumed", 0, 32'(b_st), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lit_stop_wins", 0, 32'(b_st), 32'd0);
        chk("lit_no_start",  0, 32'(b_start), 32'd0);
        idle(1);

        // Record until the small region fills.
        song_sel = 4'b0110;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        spaced_readies(13);
        chk("lit_sat_done", 1, 32'(s_dn), 32'd1);
        chk("lit_sat_addr", 1, 32'(s_addr), 32'h1B);
        chk("lit_big_addr", 0, 32'(b_addr), 32'h60004);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (16) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_sat_play", 1, 32'(s_addr), 32'h1B);
        chk("lit_big_play", 0, 32'(b_addr), 32'h60004);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a take.
        song_sel = 4'd2;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        spaced_readies(6);
        chk("lit_pre_reset", 0, 32'(b_addr), 32'h20002);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("lit_rst_outs", 0, {b_start, b_ch, b_rm, b_pz, b_dn, b_st}, 32'd0);
        chk("lit_rst_addr", 0, 32'(b_addr), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("lit_discarded", 0, 32'(b_st), 32'd5);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
